// File: rtl/maze_round_ctrl.sv
// maze_round_ctrl: level/lives sequencer that drives the maze BCD countdown timer.
// Define MAZE_ROUND_PAUSE_EN to add a PAUSE state controlled by btn_pause.
module maze_round_ctrl #(
    parameter int MAX_LIVES = 3,
    parameter int BLINK_DIV = 25000000,
    parameter int SIZE_MIN  = 5,
    parameter int SIZE_MAX  = 19
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        btn_start,
    input  logic        btn_pause,
    input  logic        goal_reached,
    input  logic        timer_zero,
    output logic [4:0]  size,
    output logic [15:0] limit_time,
    output logic        timer_load,
    output logic        timer_en,
    output logic [1:0]  lives,
    output logic [2:0]  state_code,
    output logic        blink,
    output logic        game_won
);
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_WIN   = 3'd4,
        S_LOSE  = 3'd5,
        S_OVER  = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_nxt;
    logic [4:0]         r_size;
    logic [15:0]        r_limit;
    logic [1:0]         r_lives;
    logic               r_load;
    logic               r_en;
    logic               r_blink;
    logic               r_won;
    logic [CNT_W-1:0]   r_blink_cnt;
    logic [2:0]         r_start_sync;
    logic               w_start_ev;
    logic               w_blink_st;

    function automatic logic [15:0] limit_for(input logic [4:0] s);
        case (s)
            5'd5:    return 16'h0300;
            5'd7:    return 16'h0500;
            5'd9:    return 16'h1000;
            5'd11:   return 16'h1500;
            5'd13:   return 16'h2000;
            5'd15:   return 16'h2500;
            5'd17:   return 16'h3000;
            default: return 16'h3500;
        endcase
    endfunction

    // Bits [1:0] form the synchronizer; bit 2 is the previous sample for edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_start_sync <= 3'b000;
        else       r_start_sync <= {r_start_sync[1:0], btn_start};
    end
    assign w_start_ev = r_start_sync[1] & ~r_start_sync[2];

`ifdef MAZE_ROUND_PAUSE_EN
    logic [2:0] r_pause_sync;
    logic       w_pause_ev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_pause_sync <= 3'b000;
        else       r_pause_sync <= {r_pause_sync[1:0], btn_pause};
    end
    assign w_pause_ev = r_pause_sync[1] & ~r_pause_sync[2];
`else
    logic w_pause_unused;
    assign w_pause_unused = btn_pause;
`endif

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_start_ev) w_nxt = S_LOAD;
            S_LOAD: w_nxt = S_RUN;
            S_RUN: begin
                if (goal_reached)    w_nxt = S_WIN;
                else if (timer_zero) w_nxt = S_LOSE;
`ifdef MAZE_ROUND_PAUSE_EN
                else if (w_pause_ev) w_nxt = S_PAUSE;
`endif
            end
`ifdef MAZE_ROUND_PAUSE_EN
            S_PAUSE: begin
                if (w_pause_ev)      w_nxt = S_RUN;
                else if (w_start_ev) w_nxt = S_IDLE;
            end
`endif
            S_WIN: if (w_start_ev) w_nxt = (r_size == 5'(SIZE_MAX)) ? S_OVER : S_LOAD;
            S_LOSE: begin
                if (r_lives == 2'd0) w_nxt = S_OVER;
                else if (w_start_ev) w_nxt = S_LOAD;
            end
            S_OVER: if (w_start_ev) w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    assign w_blink_st = (r_state == S_WIN) || (r_state == S_LOSE) ||
                        (r_state == S_OVER) || (r_state == S_PAUSE);

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_size      <= 5'(SIZE_MIN);
            r_limit     <= 16'h0300;
            r_lives     <= 2'(MAX_LIVES);
            r_load      <= 1'b0;
            r_en        <= 1'b0;
            r_blink     <= 1'b0;
            r_won       <= 1'b0;
            r_blink_cnt <= '0;
        end else begin
            r_state <= w_nxt;
            r_load  <= (w_nxt == S_LOAD);
            r_en    <= (w_nxt == S_RUN);

            if (w_nxt != r_state) begin
                r_blink_cnt <= '0;
                r_blink     <= 1'b0;
            end else if (w_blink_st) begin
                if (r_blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
                    r_blink_cnt <= '0;
                    r_blink     <= ~r_blink;
                end else begin
                    r_blink_cnt <= r_blink_cnt + CNT_W'(1);
                end
            end

            if (r_state == S_IDLE && w_nxt == S_LOAD) begin
                r_size  <= 5'(SIZE_MIN);
                r_limit <= limit_for(5'(SIZE_MIN));
                r_lives <= 2'(MAX_LIVES);
            end
            if (r_state == S_WIN && w_nxt == S_LOAD) begin
                r_size  <= r_size + 5'd2;
                r_limit <= limit_for(r_size + 5'd2);
            end
            if (r_state == S_RUN && w_nxt == S_LOSE)
                r_lives <= (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
            if (r_state == S_WIN && w_nxt == S_OVER)
                r_won <= 1'b1;
            if (r_state == S_OVER && w_nxt == S_IDLE)
                r_won <= 1'b0;
        end
    end

    assign size       = r_size;
    assign limit_time = r_limit;
    assign timer_load = r_load;
    assign timer_en   = r_en;
    assign lives      = r_lives;
    assign state_code = r_state;
    assign blink      = r_blink;
    assign game_won   = r_won;
endmodule

// File: tb/tb_maze_round_ctrl.sv
// tb_maze_round_ctrl: directed game scenarios with randomized timing, checked
// against a game-level model of size, lives, time limit and state progression.
module tb_maze_round_ctrl;
    logic        clk = 1'b0;
    logic        rstn;
    logic        btn_start;
    logic        btn_pause;
    logic        goal_reached;
    logic        timer_zero;
    logic [4:0]  size;
    logic [15:0] limit_time;
    logic        timer_load;
    logic        timer_en;
    logic [1:0]  lives;
    logic [2:0]  state_code;
    logic        blink;
    logic        game_won;

    int checks = 0;
    int errors = 0;
    int exp_size;
    int exp_lives;

    localparam int ST_IDLE = 0, ST_LOAD = 1, ST_RUN = 2, ST_PAUSE = 3;
    localparam int ST_WIN = 4, ST_LOSE = 5, ST_OVER = 6;

    maze_round_ctrl #(
        .MAX_LIVES(3), .BLINK_DIV(4), .SIZE_MIN(5), .SIZE_MAX(19)
    ) dut (
        .clk(clk), .rstn(rstn), .btn_start(btn_start), .btn_pause(btn_pause),
        .goal_reached(goal_reached), .timer_zero(timer_zero), .size(size),
        .limit_time(limit_time), .timer_load(timer_load), .timer_en(timer_en),
        .lives(lives), .state_code(state_code), .blink(blink), .game_won(game_won)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Time limit in seconds*100 from the level table, then packed as BCD digits.
    function automatic logic [15:0] model_limit(input int s);
        int v;
        if (s == 5)                             v = 300;
        else if (s == 7)                        v = 500;
        else if (s >= 9 && s <= 17 && s % 2 == 1) v = 1000 + (s - 9) * 250;
        else                                    v = 3500;
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Button event is acted on at the third rising edge after the raw press.
    task automatic press_start(input int hold);
        btn_start = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (i == hold) btn_start = 1'b0;
        end
        btn_start = 1'b0;
    endtask

    task automatic press_pause(input int hold);
        btn_pause = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (i == hold) btn_pause = 1'b0;
        end
        btn_pause = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"}, state_code, ST_IDLE);
        check({tag, "_size"}, size, 5);
        check({tag, "_limit"}, limit_time, 16'h0300);
        check({tag, "_lives"}, lives, 3);
        check({tag, "_load"}, timer_load, 0);
        check({tag, "_en"}, timer_en, 0);
        check({tag, "_blink"}, blink, 0);
        check({tag, "_won"}, game_won, 0);
    endtask

    task automatic check_load(input string tag);
        check({tag, "_state"}, state_code, ST_LOAD);
        check({tag, "_load"}, timer_load, 1);
        check({tag, "_en"}, timer_en, 0);
        check({tag, "_size"}, size, exp_size);
        check({tag, "_limit"}, limit_time, model_limit(exp_size));
        check({tag, "_lives"}, lives, exp_lives);
        tick();
        check({tag, "_run_state"}, state_code, ST_RUN);
        check({tag, "_run_load"}, timer_load, 0);
        check({tag, "_run_en"}, timer_en, 1);
    endtask

    task automatic lose_round(input string tag);
        timer_zero = 1'b1;
        tick();
        timer_zero = 1'b0;
        exp_lives = (exp_lives > 0) ? exp_lives - 1 : 0;
        check({tag, "_state"}, state_code, ST_LOSE);
        check({tag, "_lives"}, lives, exp_lives);
        check({tag, "_en"}, timer_en, 0);
    endtask

    task automatic win_round(input string tag);
        goal_reached = 1'b1;
        tick();
        goal_reached = 1'b0;
        check({tag, "_state"}, state_code, ST_WIN);
        check({tag, "_en"}, timer_en, 0);
        check({tag, "_lives"}, lives, exp_lives);
    endtask

    initial begin
        rstn = 1'b0;
        btn_start = 1'b0;
        btn_pause = 1'b0;
        goal_reached = 1'b0;
        timer_zero = 1'b0;
        repeat (3) tick();
        check_reset("reset");
        rstn = 1'b1;
        repeat ($urandom_range(2, 6)) tick();
        check("idle_wait", state_code, ST_IDLE);

        // First game: start, then a start press during RUN is ignored.
        exp_size = 5;
        exp_lives = 3;
        press_start($urandom_range(1, 3));
        check_load("first");
        repeat ($urandom_range(1, 5)) tick();
        check("run_hold_en", timer_en, 1);
        press_start($urandom_range(1, 3));
        check("start_in_run", state_code, ST_RUN);
        check("start_in_run_load", timer_load, 0);

`ifdef MAZE_ROUND_PAUSE_EN
        press_pause($urandom_range(1, 3));
        check("pause_state", state_code, ST_PAUSE);
        check("pause_en", timer_en, 0);
        timer_zero = 1'b1;
        goal_reached = 1'b1;
        repeat (3) tick();
        check("pause_ignore", state_code, ST_PAUSE);
        check("pause_blink0", blink, 0);
        tick();
        check("pause_blink1", blink, 1);
        timer_zero = 1'b0;
        goal_reached = 1'b0;
        tick();
        press_pause($urandom_range(1, 3));
        check("resume_state", state_code, ST_RUN);
        check("resume_en", timer_en, 1);
        check("resume_lives", lives, exp_lives);
        tick();
        press_pause($urandom_range(1, 3));
        check("pause2_state", state_code, ST_PAUSE);
        tick();
        press_start($urandom_range(1, 3));
        check("pause_abandon", state_code, ST_IDLE);
        tick();
        press_start($urandom_range(1, 3));
        check_load("restart");
`else
        press_pause($urandom_range(1, 3));
        check("pause_ignored", state_code, ST_RUN);
        check("pause_ignored_en", timer_en, 1);
`endif

        // Win at size 5, blink cadence, advance to size 7.
        win_round("win5");
        repeat (3) tick();
        check("blink_before", blink, 0);
        tick();
        check("blink_toggle", blink, 1);
        repeat (4) tick();
        check("blink_back", blink, 0);
        press_start($urandom_range(1, 3));
        exp_size = 7;
        check_load("size7");
        tick();
        check("single_load", timer_load, 0);

        // Lose three times at size 7 until game over.
        for (int n = 0; n < 3; n++) begin
            lose_round("lose");
            if (exp_lives == 0) begin
                tick();
                check("over_state", state_code, ST_OVER);
                check("over_won", game_won, 0);
            end else begin
                repeat ($urandom_range(1, 3)) tick();
                check("lose_wait", state_code, ST_LOSE);
                press_start($urandom_range(1, 3));
                check_load("retry");
            end
        end

        // Held start in OVER yields exactly one event.
        btn_start = 1'b1;
        repeat (3) tick();
        check("over_to_idle", state_code, ST_IDLE);
        check("idle_won", game_won, 0);
        repeat (6) tick();
        check("held_one_event", state_code, ST_IDLE);
        btn_start = 1'b0;
        repeat (2) tick();

        // Second game: goal wins over simultaneous timer_zero, then clear every level.
        exp_size = 5;
        exp_lives = 3;
        press_start($urandom_range(1, 3));
        check_load("game2");
        repeat ($urandom_range(0, 3)) tick();
        goal_reached = 1'b1;
        timer_zero = 1'b1;
        tick();
        goal_reached = 1'b0;
        timer_zero = 1'b0;
        check("both_state", state_code, ST_WIN);
        check("both_lives", lives, 3);
        for (int lvl = 1; lvl < 8; lvl++) begin
            repeat ($urandom_range(1, 3)) tick();
            press_start($urandom_range(1, 3));
            exp_size += 2;
            check_load("level");
            if (exp_lives > 1 && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 3)) tick();
                lose_round("level_lose");
                repeat ($urandom_range(1, 3)) tick();
                press_start($urandom_range(1, 3));
                check_load("level_retry");
            end
            repeat ($urandom_range(0, 4)) tick();
            win_round("level_win");
        end
        check("last_size", size, 19);
        check("last_limit", limit_time, 16'h3500);
        repeat ($urandom_range(1, 3)) tick();
        press_start($urandom_range(1, 3));
        check("final_over", state_code, ST_OVER);
        check("final_won", game_won, 1);
        check("final_en", timer_en, 0);
        repeat (2) tick();
        check("final_won_hold", game_won, 1);
        press_start($urandom_range(1, 3));
        check("final_idle", state_code, ST_IDLE);
        check("final_idle_won", game_won, 0);

        // Third game: reach size 7 with a lost life, then reset asynchronously mid-RUN.
        tick();
        exp_size = 5;
        exp_lives = 3;
        press_start($urandom_range(1, 3));
        check_load("game3");
        win_round("game3_win");
        tick();
        press_start($urandom_range(1, 3));
        exp_size = 7;
        check_load("game3_l2");
        lose_round("game3_lose");
        tick();
        press_start($urandom_range(1, 3));
        check_load("game3_retry");
        repeat ($urandom_range(1, 4)) tick();
        check("pre_reset_en", timer_en, 1);
        #2 rstn = 1'b0;
        #1 check_reset("async");
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_reset_load", timer_load, 0);
            check("post_reset_state", state_code, ST_IDLE);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
